// File: rtl/mul_arb_pkg.sv
// mul_arb_pkg: Q3.12 format constants and arbiter FSM state type
// shared by the mul_arbiter slice.
package mul_arb_pkg;

   localparam int DATA_W = 16;
   localparam int FRAC_W = 12;
   localparam int MAG_W  = DATA_W - 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_DRAIN
   } state_t;

endpackage

// File: rtl/mul_arbiter_rr_grant.sv
// rr_grant: round-robin one-hot grant, searching from last+1
// and wrapping around NUM_REQ requesters.
module rr_grant #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 3
) (
   input  logic               en,
   input  logic [NUM_REQ-1:0] valid,
   input  logic [ID_W-1:0]    last,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_id
);

   function automatic int rr_idx(input int l, input int k);
      return (l + k) % NUM_REQ;
   endfunction

   // Walk from farthest to nearest so the nearest valid requester wins
   always_comb begin
      grant    = '0;
      grant_id = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         if (en && valid[rr_idx(int'(last), k)]) begin
            grant                         = '0;
            grant[rr_idx(int'(last), k)]  = 1'b1;
            grant_id = ID_W'(rr_idx(int'(last), k));
         end
      end
   end

endmodule

// File: rtl/signedmul.sv
// signedmul: pipelined sign-magnitude Q3.12 multiplier.
// Operands are captured on the first edge; the signed result follows two edges later.
module signedmul
   import mul_arb_pkg::*;
(
   input  logic              clk,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] p
);

   logic [DATA_W-1:0]   ma_q;
   logic [DATA_W-1:0]   mb_q;
   logic                sa_q;
   logic [MAG_W-1:0]    mag_q;
   logic                sp_q;
   logic [2*DATA_W-1:0] prod;

   assign prod = ma_q * mb_q;

   // Data path is intentionally unreset; validity travels in the caller's tags
   always_ff @(posedge clk) begin
      ma_q  <= a[DATA_W-1] ? (~a + DATA_W'(1)) : a;
      mb_q  <= b[DATA_W-1] ? (~b + DATA_W'(1)) : b;
      sa_q  <= a[DATA_W-1] ^ b[DATA_W-1];
      mag_q <= MAG_W'(prod >> FRAC_W);
      sp_q  <= sa_q;
      p     <= sp_q ? -{1'b0, mag_q} : {1'b0, mag_q};
   end

endmodule

// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin sharing of one signedmul among NUM_REQ requesters.
// Define MUL_ARBITER_STATS_EN to add op_count/stall_count outputs.
module mul_arbiter
   import mul_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 3
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [DATA_W*NUM_REQ-1:0]  req_a,
   input  logic [DATA_W*NUM_REQ-1:0]  req_b,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic                       hold,
   output logic                       rsp_valid,
   output logic [ID_W-1:0]            rsp_id,
   output logic [DATA_W-1:0]          rsp_data,
   output logic                       idle
`ifdef MUL_ARBITER_STATS_EN
   ,
   output logic [31:0]                op_count,
   output logic [31:0]                stall_count
`endif
);

   state_t              state;
   state_t              state_nxt;
   logic                grant_en;
   logic                accept;
   logic                pipe_empty;
   logic [NUM_REQ-1:0]  grant;
   logic [ID_W-1:0]     grant_id;
   logic [ID_W-1:0]     last_grant;
   logic [DATA_W-1:0]   mul_a;
   logic [DATA_W-1:0]   mul_b;
   logic [DATA_W-1:0]   mul_p;
   logic                iss_v;
   logic [ID_W-1:0]     iss_id;
   logic [1:0]          tag_v;
   logic [ID_W-1:0]     tag_id [2];

   assign grant_en = rst_n & ~hold & (state != ST_DRAIN);

   rr_grant #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr (
      .en       (grant_en),
      .valid    (req_valid),
      .last     (last_grant),
      .grant    (grant),
      .grant_id (grant_id)
   );

   assign req_ready = grant;
   assign accept    = |grant;

   always_comb begin
      mul_a = '0;
      mul_b = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            mul_a = req_a[DATA_W*i +: DATA_W];
            mul_b = req_b[DATA_W*i +: DATA_W];
         end
      end
   end

   signedmul u_mul (
      .clk (clk),
      .a   (mul_a),
      .b   (mul_b),
      .p   (mul_p)
   );

   // Issue stage pairs with the operand capture, tags with the product stages
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= ID_W'(NUM_REQ - 1);
         iss_v      <= 1'b0;
         iss_id     <= '0;
         tag_v      <= '0;
         tag_id[0]  <= '0;
         tag_id[1]  <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= '0;
         rsp_data   <= '0;
      end else begin
         if (accept) last_grant <= grant_id;
         iss_v     <= accept;
         iss_id    <= grant_id;
         tag_v     <= {tag_v[0], iss_v};
         tag_id[0] <= iss_id;
         tag_id[1] <= tag_id[0];
         rsp_valid <= tag_v[1];
         if (tag_v[1]) begin
            rsp_id   <= tag_id[1];
            rsp_data <= mul_p;
         end
      end
   end

   assign pipe_empty = ~iss_v & ~(|tag_v) & ~rsp_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: begin
            if (accept) state_nxt = ST_BUSY;
         end
         ST_BUSY: begin
            if (hold)                       state_nxt = ST_DRAIN;
            else if (!accept && pipe_empty) state_nxt = ST_IDLE;
         end
         ST_DRAIN: begin
            if (pipe_empty) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign idle = (state == ST_IDLE) & pipe_empty;

`ifdef MUL_ARBITER_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_count    <= '0;
         stall_count <= '0;
      end else begin
         if (accept)
            op_count <= op_count + 32'd1;
         if (|req_valid && !accept)
            stall_count <= stall_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: scoreboard bench for mul_arbiter; round-robin and
// Q3.12 product expectations come from a plain-arithmetic model.
module tb_mul_arbiter;

   localparam int N  = 4;
   localparam int IW = 3;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req_valid = '0;
   logic [16*N-1:0] req_a = '0;
   logic [16*N-1:0] req_b = '0;
   logic [N-1:0]    req_ready;
   logic            hold = 1'b0;
   logic            rsp_valid;
   logic [IW-1:0]   rsp_id;
   logic [15:0]     rsp_data;
   logic            idle;
`ifdef MUL_ARBITER_STATS_EN
   logic [31:0]     op_count;
   logic [31:0]     stall_count;
`endif

   mul_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .hold      (hold),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .idle      (idle)
`ifdef MUL_ARBITER_STATS_EN
      ,
      .op_count    (op_count),
      .stall_count (stall_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int          id;
      logic [15:0] data;
      int          due;
   } exp_t;

   exp_t        sbq[$];
   exp_t        mon_e;
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          m_last = N - 1;
   int          op_m = 0;
   int          stall_m = 0;
   int          last_id = 0;
   logic [15:0] last_data = '0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] ref_mul(input logic [15:0] a,
                                           input logic [15:0] b);
      int    sa;
      int    sb;
      int    m;
      longint ma;
      longint mb;
      sa = int'($signed(a));
      sb = int'($signed(b));
      ma = (sa < 0) ? -sa : sa;
      mb = (sb < 0) ? -sb : sb;
      m  = int'(((ma * mb) >> 12) % 32768);
      if ((sa < 0) != (sb < 0)) m = -m;
      return m[15:0];
   endfunction

   function automatic int rr_pick(input logic [N-1:0] v, input int last);
      for (int k = 1; k <= N; k++)
         if (v[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   function automatic logic [15:0] rand_op();
      logic [15:0] r;
      case ($urandom % 8)
         0:       r = 16'h8000;
         1:       r = 16'h7FFF;
         2:       r = 16'h0000;
         3:       r = 16'h1000;
         default: r = 16'($urandom());
      endcase
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   // One cycle: drive inputs, compare grant to the model, log the expectation
   task automatic step(input logic [N-1:0] v, input logic h,
                       input logic [16*N-1:0] av, input logic [16*N-1:0] bv);
      int           g;
      logic [N-1:0] er;
      exp_t         e;
      @(negedge clk);
      req_valid = v;
      hold      = h;
      req_a     = av;
      req_b     = bv;
      #1;
      g  = h ? -1 : rr_pick(v, m_last);
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      checks++;
      if (req_ready !== er) begin
         failures++;
         $display("FAIL ready: got %b want %b cycle %0d", req_ready, er, cyc);
      end
      if (g >= 0) begin
         e.id   = g;
         e.data = ref_mul(av[16*g +: 16], bv[16*g +: 16]);
         e.due  = cyc + 4;
         sbq.push_back(e);
         m_last = g;
         op_m++;
      end else if (|v) begin
         stall_m++;
      end
   endtask

   task automatic rstep(input logic [N-1:0] v, input logic h);
      logic [16*N-1:0] av;
      logic [16*N-1:0] bv;
      for (int i = 0; i < N; i++) begin
         av[16*i +: 16] = rand_op();
         bv[16*i +: 16] = rand_op();
      end
      step(v, h, av, bv);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      rst_n     = 1'b0;
      req_valid = '1;
      hold      = 1'b0;
      sbq.delete();
      m_last    = N - 1;
      op_m      = 0;
      stall_m   = 0;
      last_id   = 0;
      last_data = '0;
      @(negedge clk);
      #1;
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_id", 32'(rsp_id), 32'd0);
      chk("rst_rsp_data", 32'(rsp_data), 32'd0);
      chk("rst_idle", 32'(idle), 32'd1);
      req_valid = '0;
      #1;
      rst_n = 1'b1;
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         checks++;
         if (rsp_valid) begin
            if (sbq.size() == 0) begin
               failures++;
               $display("FAIL rsp_unexpected: got id=%0d data=%h want none",
                        rsp_id, rsp_data);
            end else begin
               mon_e = sbq.pop_front();
               if (int'(rsp_id) != mon_e.id || rsp_data !== mon_e.data ||
                   cyc != mon_e.due) begin
                  failures++;
                  $display("FAIL rsp: got id=%0d data=%h cyc=%0d want id=%0d data=%h cyc=%0d",
                           rsp_id, rsp_data, cyc, mon_e.id, mon_e.data, mon_e.due);
               end
               last_id   = mon_e.id;
               last_data = mon_e.data;
            end
         end else if (int'(rsp_id) != last_id || rsp_data !== last_data) begin
            failures++;
            $display("FAIL rsp_hold: got id=%0d data=%h want id=%0d data=%h",
                     rsp_id, rsp_data, last_id, last_data);
         end
      end
   end

   initial begin
      logic [16*N-1:0] av;
      logic [16*N-1:0] bv;
      int              hold_left;
      int              rsp_seen;
      logic            h;

      do_reset();

      av = '0; bv = '0;
      av[15:0] = 16'h1000;
      bv[15:0] = 16'h2000;
      step(4'b0001, 1'b0, av, bv);
      repeat (5) rstep('0, 1'b0);

      av = '0; bv = '0;
      av[47:32] = 16'hF000;
      bv[47:32] = 16'h2000;
      step(4'b0100, 1'b0, av, bv);
      repeat (5) rstep('0, 1'b0);

      do_reset();
      repeat (8) rstep(4'b1111, 1'b0);
      repeat (6) rstep('0, 1'b0);

      rstep(4'b1111, 1'b0);
      rstep(4'b1111, 1'b0);
      rstep(4'b1111, 1'b1);
      for (int k = 0; k < 12 && !(idle && sbq.size() == 0); k++)
         rstep(4'b1111, 1'b1);
      chk("hold_idle", 32'(idle), 32'd1);
      chk("hold_drained", 32'(sbq.size()), 32'd0);
      repeat (2) rstep('0, 1'b0);

      rstep(4'b0010, 1'b0);
      do_reset();
      rsp_seen = 0;
      for (int k = 0; k < 6; k++) begin
         rstep('0, 1'b0);
         if (rsp_valid) rsp_seen++;
      end
      chk("rst_no_rsp", 32'(rsp_seen), 32'd0);
      rstep(4'b1111, 1'b0);
      repeat (5) rstep('0, 1'b0);

      hold_left = 0;
      for (int c = 0; c < 400; c++) begin
         if (hold_left > 0) begin
            h = 1'b1;
            hold_left--;
         end else if ($urandom % 25 == 0) begin
            h = 1'b1;
            hold_left = 5 + int'($urandom % 3);
         end else begin
            h = 1'b0;
         end
         rstep(N'($urandom), h);
      end
      repeat (8) rstep('0, 1'b0);
`ifdef MUL_ARBITER_STATS_EN
      chk("op_count_rand", op_count, 32'(op_m));
      chk("stall_count_rand", stall_count, 32'(stall_m));

      do_reset();
      repeat (10) rstep(N'($urandom_range(1, 15)), 1'b0);
      repeat (3) rstep(N'($urandom_range(1, 15)), 1'b1);
      repeat (8) rstep('0, 1'b0);
      chk("op_count", op_count, 32'd10);
      chk("stall_count", stall_count, 32'd3);
`endif

      for (int k = 0; k < 10 && sbq.size() != 0; k++) rstep('0, 1'b0);
      chk("final_queue", 32'(sbq.size()), 32'd0);
      chk("final_idle", 32'(idle), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
